// File: rtl/watch_set_cu.sv
// watch_set_cu: turns held "plus" buttons into single-cycle increment pulses,
// with hold-to-auto-repeat paced by an external tick strobe.
module watch_set_cu #(
  parameter int N_CH          = 3,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100,
  parameter int CNT_W         = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_plus,
  input  logic            i_tick,
  input  logic            i_repeat_en,
  output logic [N_CH-1:0] o_plus,
  output logic            o_busy,
  output logic [2:0]      o_ch
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_DELAY,
    S_REPEAT,
    S_REL_WAIT
  } state_t;

  state_t           r_state;
  logic             r_retRepeat;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_ch;

  logic [2:0]       w_first;
  logic             w_held;
  logic [N_CH-1:0]  w_onehot;
  logic [CNT_W:0]   w_limit;
  logic [CNT_W:0]   w_cntNext;
  logic             w_reach;

  // Lowest set request wins; also decode the held level and pulse vector of the locked channel.
  always_comb begin
    w_first  = 3'd0;
    w_held   = 1'b0;
    w_onehot = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_plus[i]) begin
        w_first = 3'(i);
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (r_ch == 3'(i)) begin
        w_held      = i_plus[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // Tick counter compare is done one bit wider so a saturated count never wraps.
  always_comb begin
    w_limit   = (r_state == S_DELAY) ? (CNT_W+1)'(REPEAT_DELAY) : (CNT_W+1)'(REPEAT_PERIOD);
    w_cntNext = (CNT_W+1)'(r_cnt) + (CNT_W+1)'(1);
    w_reach   = (w_cntNext >= w_limit);
  end

  // Control FSM; state, counter, lock and all outputs move together on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_retRepeat <= 1'b0;
      r_cnt       <= '0;
      r_ch        <= 3'd0;
      o_plus      <= '0;
      o_busy      <= 1'b0;
      o_ch        <= 3'd0;
    end else begin
      o_plus <= '0;
      case (r_state)
        S_IDLE: begin
          if (|i_plus) begin
            r_state     <= S_PULSE;
            r_retRepeat <= 1'b0;
            r_cnt       <= '0;
            r_ch        <= w_first;
            o_busy      <= 1'b1;
            o_ch        <= w_first;
          end
        end
        S_PULSE: begin
          o_plus  <= w_onehot;
          r_state <= r_retRepeat ? S_REPEAT : S_DELAY;
        end
        S_DELAY, S_REPEAT: begin
          if (!w_held) begin
            if (|i_plus) begin
              r_state <= S_REL_WAIT;
            end else begin
              r_state <= S_IDLE;
              r_ch    <= 3'd0;
              o_busy  <= 1'b0;
              o_ch    <= 3'd0;
            end
          end else if (i_tick) begin
            if (w_reach) begin
              if (i_repeat_en) begin
                r_state     <= S_PULSE;
                r_retRepeat <= 1'b1;
                r_cnt       <= '0;
              end else begin
                r_cnt <= w_limit[CNT_W-1:0];
              end
            end else begin
              r_cnt <= w_cntNext[CNT_W-1:0];
            end
          end
        end
        S_REL_WAIT: begin
          if (i_plus == '0) begin
            r_state <= S_IDLE;
            r_ch    <= 3'd0;
            o_busy  <= 1'b0;
            o_ch    <= 3'd0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ch    <= 3'd0;
          o_busy  <= 1'b0;
          o_ch    <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_watch_set_cu.sv
// tb_watch_set_cu: directed scenario bench for watch_set_cu (delay 5 ticks, period 2 ticks).
module tb_watch_set_cu;

  logic       clk;
  logic       rst;
  logic [2:0] iPlus;
  logic       iTick;
  logic       iRepeatEn;
  logic [2:0] oPlus;
  logic       oBusy;
  logic [2:0] oCh;

  int errors = 0;
  int checks = 0;

  watch_set_cu #(
    .N_CH(3),
    .REPEAT_DELAY(5),
    .REPEAT_PERIOD(2),
    .CNT_W(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_plus(iPlus),
    .i_tick(iTick),
    .i_repeat_en(iRepeatEn),
    .o_plus(oPlus),
    .o_busy(oBusy),
    .o_ch(oCh)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; iPlus = 3'b000; iTick = 1'b0; iRepeatEn = 1'b1;
    step(); step();
    checks++; if (oPlus !== 3'b000) begin errors++; $display("[TB] FAIL reset_plus: got %b expected 000", oPlus); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", oBusy); end
    checks++; if (oCh !== 3'd0) begin errors++; $display("[TB] FAIL reset_ch: got %0d expected 0", oCh); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_short_press;
    int pulses;
    pulses = 0;
    iPlus = 3'b010;
    step();
    checks++; if (oPlus !== 3'b000) begin errors++; $display("[TB] FAIL short_early: got %b expected 000", oPlus); end
    checks++; if (oBusy !== 1'b1) begin errors++; $display("[TB] FAIL short_busy: got %b expected 1", oBusy); end
    checks++; if (oCh !== 3'd1) begin errors++; $display("[TB] FAIL short_ch: got %0d expected 1", oCh); end
    step();
    checks++; if (oPlus !== 3'b010) begin errors++; $display("[TB] FAIL short_pulse: got %b expected 010", oPlus); end
    for (int i = 0; i < 18; i++) begin
      step();
      if (oPlus !== 3'b000) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL short_extra: got %0d pulses expected 0", pulses); end
    iPlus = 3'b000;
    step();
    checks++; if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL short_idle_busy: got %b expected 0", oBusy); end
    checks++; if (oCh !== 3'd0) begin errors++; $display("[TB] FAIL short_idle_ch: got %0d expected 0", oCh); end
  endtask

  task automatic test_auto_repeat;
    int pulses, stray, post, firstAt, secondAt, backToBack;
    logic prevPulse;
    pulses = 0; stray = 0; post = 0; firstAt = -1; secondAt = -1; backToBack = 0; prevPulse = 1'b0;
    for (int i = 0; i < 60; i++) begin
      iPlus = 3'b001;
      iTick = ((i % 4) == 0);
      step();
      if (oPlus == 3'b001) begin
        pulses++;
        if (firstAt < 0) firstAt = i;
        else if (secondAt < 0) secondAt = i;
        if (prevPulse) backToBack++;
      end else if (oPlus !== 3'b000) begin
        stray++;
      end
      prevPulse = (oPlus != 3'b000);
    end
    iPlus = 3'b000; iTick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (oPlus !== 3'b000) post++;
    end
    checks++; if (pulses !== 6) begin errors++; $display("[TB] FAIL repeat_count: got %0d expected 6", pulses); end
    checks++; if (firstAt !== 1) begin errors++; $display("[TB] FAIL repeat_first: got %0d expected 1", firstAt); end
    checks++; if (secondAt !== 21) begin errors++; $display("[TB] FAIL repeat_second: got %0d expected 21", secondAt); end
    checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL repeat_stray: got %0d expected 0", stray); end
    checks++; if (backToBack !== 0) begin errors++; $display("[TB] FAIL repeat_adjacent: got %0d expected 0", backToBack); end
    checks++; if (post !== 0) begin errors++; $display("[TB] FAIL repeat_after_release: got %0d expected 0", post); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL repeat_idle: got %b expected 0", oBusy); end
  endtask

  task automatic test_priority;
    int pulses;
    pulses = 0;
    iPlus = 3'b110;
    step();
    checks++; if (oCh !== 3'd1) begin errors++; $display("[TB] FAIL prio_ch: got %0d expected 1", oCh); end
    step();
    checks++; if (oPlus !== 3'b010) begin errors++; $display("[TB] FAIL prio_pulse: got %b expected 010", oPlus); end
    iPlus = 3'b111;
    for (int i = 0; i < 10; i++) begin
      step();
      if (oPlus !== 3'b000) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL prio_late_bit0: got %0d pulses expected 0", pulses); end
    checks++; if (oCh !== 3'd1) begin errors++; $display("[TB] FAIL prio_ch_kept: got %0d expected 1", oCh); end
    iPlus = 3'b000;
    step();
    checks++; if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL prio_idle: got %b expected 0", oBusy); end
  endtask

  task automatic test_rel_wait;
    int pulses;
    pulses = 0;
    iPlus = 3'b001;
    step(); step();
    checks++; if (oPlus !== 3'b001) begin errors++; $display("[TB] FAIL relw_first: got %b expected 001", oPlus); end
    iPlus = 3'b101;
    step();
    iPlus = 3'b100;
    for (int i = 0; i < 10; i++) begin
      iTick = 1'b1;
      step();
      if (oPlus !== 3'b000) pulses++;
    end
    iTick = 1'b0;
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL relw_no_pulse: got %0d expected 0", pulses); end
    checks++; if (oBusy !== 1'b1) begin errors++; $display("[TB] FAIL relw_busy: got %b expected 1", oBusy); end
    iPlus = 3'b000;
    step();
    checks++; if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL relw_idle: got %b expected 0", oBusy); end
    checks++; if (oCh !== 3'd0) begin errors++; $display("[TB] FAIL relw_idle_ch: got %0d expected 0", oCh); end
  endtask

  task automatic test_repeat_disabled;
    int pulses;
    pulses = 0;
    iRepeatEn = 1'b0;
    iPlus = 3'b100;
    for (int i = 0; i < 1000; i++) begin
      iTick = 1'b1;
      step();
      if (oPlus == 3'b100) pulses++;
      else if (oPlus !== 3'b000) pulses += 100;
    end
    checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL norep_count: got %0d expected 1", pulses); end
    iRepeatEn = 1'b1;
    iTick = 1'b1;
    step();
    iTick = 1'b0;
    checks++; if (oPlus !== 3'b000) begin errors++; $display("[TB] FAIL norep_enable_early: got %b expected 000", oPlus); end
    step();
    checks++; if (oPlus !== 3'b100) begin errors++; $display("[TB] FAIL norep_enable_pulse: got %b expected 100", oPlus); end
    iPlus = 3'b000;
    step(); step();
    checks++; if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL norep_idle: got %b expected 0", oBusy); end
  endtask

  task automatic test_reset_mid;
    iPlus = 3'b001;
    step(); step();
    checks++; if (oPlus !== 3'b001) begin errors++; $display("[TB] FAIL rst_pre_pulse: got %b expected 001", oPlus); end
    #2 rst = 1'b1;
    #1;
    checks++; if (oPlus !== 3'b000) begin errors++; $display("[TB] FAIL rst_async_plus: got %b expected 000", oPlus); end
    step();
    rst = 1'b0;
    iPlus = 3'b000;
    step();
    iPlus = 3'b001;
    step();
    checks++; if (oBusy !== 1'b1) begin errors++; $display("[TB] FAIL rst_pulse_state: got %b expected 1", oBusy); end
    rst = 1'b1;
    #1;
    checks++; if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", oBusy); end
    checks++; if (oCh !== 3'd0) begin errors++; $display("[TB] FAIL rst_ch: got %0d expected 0", oCh); end
    step();
    checks++; if (oPlus !== 3'b000) begin errors++; $display("[TB] FAIL rst_no_trailing: got %b expected 000", oPlus); end
    rst = 1'b0;
    step();
    checks++; if (oPlus !== 3'b000) begin errors++; $display("[TB] FAIL rst_fresh_early: got %b expected 000", oPlus); end
    step();
    checks++; if (oPlus !== 3'b001) begin errors++; $display("[TB] FAIL rst_fresh_pulse: got %b expected 001", oPlus); end
    iPlus = 3'b000;
    step(); step();
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_short_press();
    test_auto_repeat();
    test_priority();
    test_rel_wait();
    test_repeat_disabled();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
